// File: rtl/alu_rs_pkg.sv
// Shared widths, opcode constants and the reservation-station entry type for alu_rs.
package alu_rs_pkg;

  localparam int OPCODE_WID  = 7;
  localparam int FUNC3_WID   = 3;
  localparam int DATA_WID    = 32;
  localparam int ADDR_WID    = 32;
  localparam int ROB_POS_WID = 4;
  localparam int RS_SIZE     = 16;
  localparam int RS_POS_WID  = 4;

  localparam logic [OPCODE_WID-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_WID-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_WID-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_WID-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_WID-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_WID-1:0] OPC_ARITHI = 7'b0010011;
  localparam logic [OPCODE_WID-1:0] OPC_ARITH  = 7'b0110011;

  typedef struct packed {
    logic                   busy;
    logic [OPCODE_WID-1:0]  opcode;
    logic [FUNC3_WID-1:0]   func3;
    logic                   func1;
    logic [DATA_WID-1:0]    val1;
    logic [DATA_WID-1:0]    val2;
    logic [ROB_POS_WID-1:0] q1;
    logic [ROB_POS_WID-1:0] q2;
    logic                   q1_busy;
    logic                   q2_busy;
    logic [DATA_WID-1:0]    imm;
    logic [ADDR_WID-1:0]    pc;
    logic [ROB_POS_WID-1:0] rob_pos;
  } rs_entry_t;

  // Returns {still_pending, value}; the ALU broadcast wins when both CDBs match.
  function automatic logic [DATA_WID:0] fwd_operand(
    input logic [DATA_WID-1:0]    val,
    input logic [ROB_POS_WID-1:0] q,
    input logic                   pending,
    input logic                   a_valid,
    input logic [ROB_POS_WID-1:0] a_tag,
    input logic [DATA_WID-1:0]    a_val,
    input logic                   l_valid,
    input logic [ROB_POS_WID-1:0] l_tag,
    input logic [DATA_WID-1:0]    l_val
  );
    fwd_operand = {pending, val};
    if (pending) begin
      if (a_valid && a_tag == q)      fwd_operand = {1'b0, a_val};
      else if (l_valid && l_tag == q) fwd_operand = {1'b0, l_val};
    end
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder: reports the first set bit of a mask and whether any bit is set.
module alu_rs_pick #(
  parameter int WIDTH    = 16,
  parameter int IDX_BITS = 4
) (
  input  logic [WIDTH-1:0]    mask,
  output logic [IDX_BITS-1:0] idx,
  output logic                found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_BITS'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops until operands arrive, snoops both CDBs, issues one per cycle.
// Optional same-edge bypass of fully ready instructions is enabled by defining ALU_RS_BYPASS_EN.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE     = alu_rs_pkg::RS_SIZE,
  parameter int RS_POS_BITS = alu_rs_pkg::RS_POS_WID
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   issue_valid,
  input  logic [OPCODE_WID-1:0]  issue_opcode,
  input  logic [FUNC3_WID-1:0]   issue_func3,
  input  logic                   issue_func1,
  input  logic [DATA_WID-1:0]    issue_val1,
  input  logic [DATA_WID-1:0]    issue_val2,
  input  logic [ROB_POS_WID-1:0] issue_q1,
  input  logic [ROB_POS_WID-1:0] issue_q2,
  input  logic                   issue_q1_busy,
  input  logic                   issue_q2_busy,
  input  logic [DATA_WID-1:0]    issue_imm,
  input  logic [ADDR_WID-1:0]    issue_pc,
  input  logic [ROB_POS_WID-1:0] issue_rob_pos,
  output logic                   rs_full,
  input  logic                   alu_cdb_valid,
  input  logic [ROB_POS_WID-1:0] alu_cdb_rob_pos,
  input  logic [DATA_WID-1:0]    alu_cdb_val,
  input  logic                   lsb_cdb_valid,
  input  logic [ROB_POS_WID-1:0] lsb_cdb_rob_pos,
  input  logic [DATA_WID-1:0]    lsb_cdb_val,
  output logic                   alu_en,
  output logic [OPCODE_WID-1:0]  alu_opcode,
  output logic [FUNC3_WID-1:0]   alu_func3,
  output logic                   alu_func1,
  output logic [DATA_WID-1:0]    alu_val1,
  output logic [DATA_WID-1:0]    alu_val2,
  output logic [DATA_WID-1:0]    alu_imm,
  output logic [ADDR_WID-1:0]    alu_pc,
  output logic [ROB_POS_WID-1:0] alu_rob_pos
);

  rs_entry_t              ent [RS_SIZE];
  rs_entry_t              new_entry;
  rs_entry_t              dispatch_src;
  logic [RS_SIZE-1:0]     free_mask;
  logic [RS_SIZE-1:0]     ready_mask;
  logic [RS_POS_BITS-1:0] free_idx;
  logic [RS_POS_BITS-1:0] sel_idx;
  logic                   free_found;
  logic                   ready_found;
  logic                   accept;
  logic                   bypass_go;

  always_comb begin
    free_mask  = '0;
    ready_mask = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_mask[i]  = ~ent[i].busy;
      ready_mask[i] = ent[i].busy & ~ent[i].q1_busy & ~ent[i].q2_busy;
    end
  end

  alu_rs_pick #(.WIDTH(RS_SIZE), .IDX_BITS(RS_POS_BITS)) u_free_pick (
    .mask  (free_mask),
    .idx   (free_idx),
    .found (free_found)
  );

  alu_rs_pick #(.WIDTH(RS_SIZE), .IDX_BITS(RS_POS_BITS)) u_ready_pick (
    .mask  (ready_mask),
    .idx   (sel_idx),
    .found (ready_found)
  );

  assign rs_full = ~free_found;
  assign accept  = issue_valid & ~rs_full;

  // Incoming instruction with same-cycle CDB results already folded in.
  always_comb begin
    new_entry         = '0;
    new_entry.busy    = 1'b1;
    new_entry.opcode  = issue_opcode;
    new_entry.func3   = issue_func3;
    new_entry.func1   = issue_func1;
    new_entry.q1      = issue_q1;
    new_entry.q2      = issue_q2;
    new_entry.imm     = issue_imm;
    new_entry.pc      = issue_pc;
    new_entry.rob_pos = issue_rob_pos;
    {new_entry.q1_busy, new_entry.val1} = fwd_operand(issue_val1, issue_q1, issue_q1_busy,
      alu_cdb_valid, alu_cdb_rob_pos, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob_pos, lsb_cdb_val);
    {new_entry.q2_busy, new_entry.val2} = fwd_operand(issue_val2, issue_q2, issue_q2_busy,
      alu_cdb_valid, alu_cdb_rob_pos, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob_pos, lsb_cdb_val);
  end

`ifdef ALU_RS_BYPASS_EN
  assign bypass_go = accept & ~new_entry.q1_busy & ~new_entry.q2_busy & ~ready_found;
`else
  assign bypass_go = 1'b0;
`endif

  assign dispatch_src = ready_found ? ent[sel_idx] : new_entry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_func3   <= '0;
      alu_func1   <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      if (rollback) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
        alu_en <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent[i].busy) begin
            {ent[i].q1_busy, ent[i].val1} <= fwd_operand(ent[i].val1, ent[i].q1, ent[i].q1_busy,
              alu_cdb_valid, alu_cdb_rob_pos, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob_pos, lsb_cdb_val);
            {ent[i].q2_busy, ent[i].val2} <= fwd_operand(ent[i].val2, ent[i].q2, ent[i].q2_busy,
              alu_cdb_valid, alu_cdb_rob_pos, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob_pos, lsb_cdb_val);
          end
        end
        // The dispatched entry is busy and the allocated one is free, so they never collide.
        if (ready_found || bypass_go) begin
          alu_en      <= 1'b1;
          alu_opcode  <= dispatch_src.opcode;
          alu_func3   <= dispatch_src.func3;
          alu_func1   <= dispatch_src.func1;
          alu_val1    <= dispatch_src.val1;
          alu_val2    <= dispatch_src.val2;
          alu_imm     <= dispatch_src.imm;
          alu_pc      <= dispatch_src.pc;
          alu_rob_pos <= dispatch_src.rob_pos;
          if (ready_found) ent[sel_idx].busy <= 1'b0;
        end else begin
          alu_en <= 1'b0;
        end
        if (accept && !bypass_go) ent[free_idx] <= new_entry;
      end
    end
  end

endmodule
